// File: rtl/tone_pkg.sv
// Shared types and constants for the tone table reader slice.
package tone_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

  localparam logic [7:0] ENV_MAX = 8'hFF;

  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/tone_envelope.sv
// Attack/sustain/release envelope generator, advanced once per sample tick.
module tone_envelope
  import tone_pkg::*;
#(
  parameter int unsigned ATK_STEP = 8,
  parameter int unsigned REL_STEP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       note_on,
  output logic [7:0] env,
  output env_state_t state,
  output logic       phase_clr
);

  localparam logic [7:0] ATK_B = 8'(ATK_STEP);
  localparam logic [7:0] REL_B = 8'(REL_STEP);

  env_state_t state_q, state_d;
  logic [7:0] env_q, env_d;
  logic [8:0] atk_sum;

  always_comb begin
    state_d   = state_q;
    env_d     = env_q;
    phase_clr = 1'b0;
    atk_sum   = {1'b0, env_q} + {1'b0, ATK_B};
    if (sample_tick) begin
      case (state_q)
        ENV_IDLE: begin
          if (note_on) begin
            phase_clr = 1'b1;
            env_d     = ATK_B;
            state_d   = (ATK_B == ENV_MAX) ? ENV_SUSTAIN : ENV_ATTACK;
          end
        end
        ENV_ATTACK: begin
          if (!note_on) begin
            state_d = ENV_RELEASE;
          end else if (atk_sum >= 9'd255) begin
            env_d   = ENV_MAX;
            state_d = ENV_SUSTAIN;
          end else begin
            env_d = atk_sum[7:0];
          end
        end
        ENV_SUSTAIN: begin
          env_d = ENV_MAX;
          if (!note_on) state_d = ENV_RELEASE;
        end
        ENV_RELEASE: begin
          // Retrigger resumes attack from the current level, not from zero.
          if (note_on) begin
            state_d = ENV_ATTACK;
          end else if (env_q <= REL_B) begin
            env_d   = '0;
            state_d = ENV_IDLE;
          end else begin
            env_d = env_q - REL_B;
          end
        end
        default: state_d = ENV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ENV_IDLE;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  assign env   = env_q;
  assign state = state_q;

endmodule

// File: rtl/tone_table_reader.sv
// Phase accumulator driving a registered waveform table, with envelope-scaled sample output.
module tone_table_reader
  import tone_pkg::*;
#(
  parameter int unsigned COUNT_SIZE = 8,
  parameter int unsigned PHASE_W    = 24,
  parameter int unsigned ATK_STEP   = 8,
  parameter int unsigned REL_STEP   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  note_on,
  input  logic [PHASE_W-1:0]    freq_word,
  output logic [COUNT_SIZE-1:0] table_addr,
  input  logic [15:0]           table_q,
  output logic signed [15:0]    sample_out,
  output logic                  sample_valid,
  output logic                  busy
);

  env_state_t env_state;
  logic [7:0] env;
  logic       phase_clr;

  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [COUNT_SIZE-1:0] addr_q, addr_d;
  logic                  tick_p1_q, tick_p1_d;
  logic                  tick_p2_q, tick_p2_d;
  logic [7:0]            env_p2_q, env_p2_d;
  sample_t               sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic signed [15:0]    mul_a, mul_b, prod;
  logic                  unused_table_hi;

  tone_envelope #(
    .ATK_STEP(ATK_STEP),
    .REL_STEP(REL_STEP)
  ) u_env (
    .clk        (clk),
    .reset      (reset),
    .sample_tick(sample_tick),
    .note_on    (note_on),
    .env        (env),
    .state      (env_state),
    .phase_clr  (phase_clr)
  );

  always_comb begin
    phase_d = phase_q;
    if (sample_tick) begin
      if (phase_clr)                   phase_d = '0;
      else if (env_state != ENV_IDLE)  phase_d = phase_q + freq_word;
    end
    addr_d    = phase_d[PHASE_W-1 -: COUNT_SIZE];
    tick_p1_d = sample_tick;
    tick_p2_d = tick_p1_q;
    // env_q one edge after the tick is the post-update level for that tick.
    env_p2_d  = env;
    mul_a     = $signed({{8{table_q[7]}}, table_q[7:0]});
    mul_b     = $signed({8'h00, env_p2_q});
    prod      = mul_a * mul_b;
    sample_d  = tick_p2_q ? prod : sample_q;
    valid_d   = tick_p2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= '0;
      addr_q    <= '0;
      tick_p1_q <= 1'b0;
      tick_p2_q <= 1'b0;
      env_p2_q  <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      tick_p1_q <= tick_p1_d;
      tick_p2_q <= tick_p2_d;
      env_p2_q  <= env_p2_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
    end
  end

  assign unused_table_hi = ^table_q[15:8];
  assign table_addr      = addr_q;
  assign sample_out      = sample_q;
  assign sample_valid    = valid_q;
  assign busy            = (env_state != ENV_IDLE);

endmodule

// File: tb/tb_tone_table_reader.sv
// Directed bench for tone_table_reader: fast-attack and slow-attack instances with a registered table model.
module tb_tone_table_reader;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        note;
  logic        sel;
  logic [23:0] freq;

  logic               a_tick, b_tick;
  logic [7:0]         a_addr, b_addr;
  logic [15:0]        a_tq, b_tq;
  logic signed [15:0] a_sample, b_sample;
  logic               a_valid, b_valid, a_busy, b_busy;

  logic [7:0]         o_addr;
  logic signed [15:0] o_sample;
  logic               o_valid, o_busy;

  int checks = 0;
  int errors = 0;

  assign a_tick   = tick & ~sel;
  assign b_tick   = tick & sel;
  assign o_addr   = sel ? b_addr : a_addr;
  assign o_sample = sel ? b_sample : a_sample;
  assign o_valid  = sel ? b_valid : a_valid;
  assign o_busy   = sel ? b_busy : a_busy;

  tone_table_reader #(.COUNT_SIZE(8), .PHASE_W(24), .ATK_STEP(255), .REL_STEP(64)) u_dut_a (
    .clk(clk), .reset(reset), .sample_tick(a_tick), .note_on(note), .freq_word(freq),
    .table_addr(a_addr), .table_q(a_tq), .sample_out(a_sample), .sample_valid(a_valid),
    .busy(a_busy)
  );

  tone_table_reader #(.COUNT_SIZE(8), .PHASE_W(24), .ATK_STEP(16), .REL_STEP(64)) u_dut_b (
    .clk(clk), .reset(reset), .sample_tick(b_tick), .note_on(note), .freq_word(freq),
    .table_addr(b_addr), .table_q(b_tq), .sample_out(b_sample), .sample_valid(b_valid),
    .busy(b_busy)
  );

  // Table content: low byte is the sample, high byte is deliberately unrelated garbage.
  function automatic logic [15:0] tbl(input logic [7:0] a);
    logic [7:0] lo;
    lo = a * 8'd37 + 8'd5;
    return {~a, lo};
  endfunction

  function automatic int exp_s(input logic [7:0] a, input int e);
    logic [15:0]       t;
    logic signed [7:0] s;
    t = tbl(a);
    s = t[7:0];
    return int'(s) * e;
  endfunction

  always_ff @(posedge clk) begin
    a_tq <= tbl(a_addr);
    b_tq <= tbl(b_addr);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One isolated tick: addr/busy after the accepting edge, pulse exactly 3 cycles later, then hold.
  task automatic do_tick(input logic nt, input logic [7:0] e_addr, input int e_env,
                         input logic e_busy, input string tag);
    @(negedge clk); note = nt; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    check({tag, "_addr"}, 32'(o_addr), 32'(e_addr));
    check({tag, "_busy"}, 32'(o_busy), 32'(e_busy));
    check({tag, "_v1"}, 32'(o_valid), 0);
    @(negedge clk);
    check({tag, "_v2"}, 32'(o_valid), 0);
    @(negedge clk);
    check({tag, "_v3"}, 32'(o_valid), 1);
    check({tag, "_smp"}, o_sample, exp_s(e_addr, e_env));
    @(negedge clk);
    check({tag, "_v4"}, 32'(o_valid), 0);
    check({tag, "_hold"}, o_sample, exp_s(e_addr, e_env));
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; note = 1'b0; sel = 1'b0; freq = 24'h010000;
    #2 reset = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_addr", 32'(o_addr), 0);
      check("rst_smp", o_sample, 0);
      check("rst_valid", 32'(o_valid), 0);
      check("rst_busy", 32'(o_busy), 0);
    end
    @(negedge clk); reset = 1'b0; sel = 1'b0;

    // Instance A: ATK_STEP=255 jumps straight to sustain.
    do_tick(1'b1, 8'd0, 255, 1'b1, "a_t0");
    repeat (6) @(negedge clk);
    do_tick(1'b1, 8'd1, 255, 1'b1, "a_t1");
    repeat (6) @(negedge clk);
    do_tick(1'b1, 8'd2, 255, 1'b1, "a_t2");
    note = 1'b0;
    repeat (3) @(negedge clk);
    do_tick(1'b1, 8'd3, 255, 1'b1, "a_glitch");
    do_tick(1'b0, 8'd4, 255, 1'b1, "a_rel0");
    do_tick(1'b0, 8'd5, 191, 1'b1, "a_rel1");
    do_tick(1'b0, 8'd6, 127, 1'b1, "a_rel2");
    do_tick(1'b0, 8'd7, 63, 1'b1, "a_rel3");
    do_tick(1'b0, 8'd8, 0, 1'b0, "a_rel4");
    do_tick(1'b0, 8'd8, 0, 1'b0, "a_idle");

    // Instance B: ATK_STEP=16 ramps through attack.
    sel = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      do_tick(1'b1, 8'(k - 1), 16 * k, 1'b1, "b_atk");
    end
    do_tick(1'b1, 8'd15, 255, 1'b1, "b_sus");
    do_tick(1'b0, 8'd16, 255, 1'b1, "b_rel0");
    do_tick(1'b0, 8'd17, 191, 1'b1, "b_rel1");
    do_tick(1'b0, 8'd18, 127, 1'b1, "b_rel2");
    do_tick(1'b1, 8'd19, 127, 1'b1, "b_retrig");
    do_tick(1'b1, 8'd20, 143, 1'b1, "b_reatk");

    // Reset with two ticks in flight while attacking.
    @(negedge clk); note = 1'b1; tick = 1'b1;
    @(negedge clk);
    @(negedge clk); tick = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(o_valid), 0);
    check("mid_rst_smp", o_sample, 0);
    check("mid_rst_addr", 32'(o_addr), 0);
    check("mid_rst_busy", 32'(o_busy), 0);
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("mid_rst_quiet", 32'(o_valid), 0);
    end
    do_tick(1'b1, 8'd0, 16, 1'b1, "b_post_rst");

    freq = 24'hF70000;
    do_tick(1'b1, 8'hF7, 32, 1'b1, "b_jump");

    // Nine back-to-back ticks crossing the address wrap.
    freq = 24'h010000;
    @(negedge clk); tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      int j;
      logic [7:0] ea;
      @(negedge clk);
      if (c == 9) tick = 1'b0;
      if (c <= 9) begin
        ea = 8'hF8 + 8'(c - 1);
        check("bb_addr", 32'(o_addr), 32'(ea));
      end
      j = c - 3;
      if (j >= 0 && j < 9) begin
        ea = 8'hF8 + 8'(j);
        check("bb_valid", 32'(o_valid), 1);
        check("bb_smp", o_sample, exp_s(ea, 48 + 16 * j));
      end else begin
        check("bb_valid", 32'(o_valid), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
